// File: rtl/divider_if.sv
// divider_if: start/operand and result/flag signals between ALU control and the sequential divider
interface divider_if #(parameter int N = 8);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic [3:0]   flags;
    modport master (output start, a, b, input busy, done, quotient, remainder, flags);
    modport slave  (input start, a, b, output busy, done, quotient, remainder, flags);
endinterface

// File: rtl/divider_seq.sv
// divider_seq: iterative unsigned restoring divider, one quotient bit per clock, flags {N,Z,C,V}
module divider_seq #(parameter int N = 8) (
    input logic clk,
    input logic rst,
    divider_if.slave bus
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state;
    logic [N-1:0] rem, q, d, nq, nrem;
    logic [N:0] sh, trial;
    logic [CW-1:0] cnt;
    // q starts as the dividend and is shifted out MSB-first as quotient bits shift in
    always_comb begin
        sh = {rem, q[N-1]};
        trial = sh - {1'b0, d};
        nq = {q[N-2:0], ~trial[N]};
        nrem = trial[N] ? sh[N-1:0] : trial[N-1:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem <= '0;
            q <= '0;
            d <= '0;
            cnt <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.quotient <= '0;
            bus.remainder <= '0;
            bus.flags <= 4'b0000;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    if (bus.b != '0) begin
                        q <= bus.a;
                        d <= bus.b;
                        rem <= '0;
                        cnt <= '0;
                        bus.busy <= 1'b1;
                        state <= CALC;
                    end else begin
                        bus.quotient <= '1;
                        bus.remainder <= bus.a;
                        bus.flags <= 4'b1001;
                        bus.done <= 1'b1;
                        state <= DONE;
                    end
                end
                CALC: begin
                    rem <= nrem;
                    q <= nq;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        bus.quotient <= nq;
                        bus.remainder <= nrem;
                        bus.flags <= {nq[N-1], nq == '0, 2'b00};
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: vector table, corner sequences and random division checks for N=4 and N=8 dividers
module tb_divider_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    divider_if #(4) if4();
    divider_if #(8) if8();
    divider_seq #(.N(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
    divider_seq #(.N(8)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));

    logic sel = 1'b0, st = 1'b0;
    logic [7:0] av = '0, bv = '0;
    assign if4.start = st & ~sel;
    assign if4.a = av[3:0];
    assign if4.b = bv[3:0];
    assign if8.start = st & sel;
    assign if8.a = av;
    assign if8.b = bv;

    logic busy_s, done_s;
    logic [7:0] q_s, r_s;
    logic [3:0] f_s;
    assign busy_s = sel ? if8.busy : if4.busy;
    assign done_s = sel ? if8.done : if4.done;
    assign q_s = sel ? if8.quotient : {4'b0, if4.quotient};
    assign r_s = sel ? if8.remainder : {4'b0, if4.remainder};
    assign f_s = sel ? if8.flags : if4.flags;

    int vecs = 0, miss = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic void model(input bit w, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r, output logic [3:0] f);
        int n = w ? 8 : 4;
        if (b == 0) begin
            q = w ? 8'hff : 8'h0f;
            r = a;
            f = 4'b1001;
        end else begin
            q = a / b;
            r = a % b;
            f = {q[n-1], q == 0, 2'b00};
        end
    endfunction

    task automatic op(input bit w, input logic [7:0] a, input logic [7:0] b, output int lat, output int bc);
        sel = w;
        av = a;
        bv = b;
        st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        av = 8'($urandom);
        bv = 8'($urandom);
        lat = 0;
        bc = 0;
        while (!done_s && lat < 40) begin
            bc += int'(busy_s);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic apply(input string n, input bit w, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] q, input logic [7:0] r, input logic [3:0] f);
        int lat, bc, el;
        el = (b == 0) ? 0 : (w ? 8 : 4);
        op(w, a, b, lat, bc);
        chk({n, " latency"}, lat, el);
        chk({n, " busy cycles"}, bc, el);
        chk({n, " busy at done"}, busy_s, 0);
        chk({n, " quotient"}, q_s, q);
        chk({n, " remainder"}, r_s, r);
        chk({n, " flags"}, f_s, f);
        @(posedge clk); #1;
        chk({n, " done single pulse"}, done_s, 0);
        chk({n, " quotient held"}, q_s, q);
    endtask

    typedef struct {
        bit w;
        logic [7:0] a, b, q, r;
        logic [3:0] f;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int cyc, seen;
        logic [7:0] eq, er;
        logic [3:0] ef;
        tbl[0] = '{0, 8'd10, 8'd6, 8'd1, 8'd4, 4'b0000};
        tbl[1] = '{1, 8'd250, 8'd56, 8'd4, 8'd26, 4'b0000};
        tbl[2] = '{0, 8'd3, 8'd6, 8'd0, 8'd3, 4'b0100};
        tbl[3] = '{0, 8'd15, 8'd1, 8'd15, 8'd0, 4'b1000};
        tbl[4] = '{0, 8'd7, 8'd0, 8'd15, 8'd7, 4'b1001};
        tbl[5] = '{1, 8'd9, 8'd3, 8'd3, 8'd0, 4'b0000};

        repeat (2) @(posedge clk);
        #1;
        chk("reset n4 outputs", {if4.busy, if4.done, if4.quotient, if4.remainder, if4.flags}, 0);
        chk("reset n8 outputs", {if8.busy, if8.done, if8.quotient, if8.remainder, if8.flags}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            apply($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].f);

        // second start while busy must be ignored
        sel = 1'b1;
        av = 8'd250;
        bv = 8'd56;
        st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        cyc = 0;
        repeat (2) begin
            @(posedge clk); #1;
            cyc++;
        end
        av = 8'd9;
        bv = 8'd3;
        st = 1'b1;
        @(posedge clk); #1;
        cyc++;
        st = 1'b0;
        while (!done_s && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("busy start latency", cyc, 8);
        chk("busy start quotient", q_s, 4);
        chk("busy start remainder", r_s, 26);
        @(posedge clk); #1;

        // asynchronous reset in the middle of a division
        av = 8'd100;
        bv = 8'd7;
        st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst busy", busy_s, 0);
        chk("midrst done", done_s, 0);
        chk("midrst outputs", {q_s, r_s, f_s}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            seen |= int'(done_s);
        end
        chk("midrst no done", seen, 0);
        apply("after rst", 1, 8'd9, 8'd3, 8'd3, 8'd0, 4'b0000);

        for (int i = 0; i < 40; i++) begin
            bit w;
            logic [7:0] a, b;
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if (!w) begin
                a &= 8'h0f;
                b &= 8'h0f;
            end
            model(w, a, b, eq, er, ef);
            apply($sformatf("rnd%0d n%0d %0d/%0d", i, w ? 8 : 4, a, b), w, a, b, eq, er, ef);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Iterative unsigned restoring divider for the processor ALU.
- Uses repeated trial subtraction, one quotient bit per clock.
- Multi-cycle partner to the combinational subtractor/adder path; used for DIV/MOD operations.
- Produces quotient, remainder and a 4-bit flag vector {N,Z,C,V}. The ALU control stalls on busy and captures results on done.

Parameters:
- N, 8, operand/result width in bits (N >= 2).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- a  input  N  dividend (unsigned).
- b  input  N  divisor (unsigned).
- busy  output  1  high while an operation is in progress (CALC state).
- done  output  1  single-cycle pulse; results are valid from this cycle.
- quotient  output  N  registered quotient.
- remainder  output  N  registered remainder.
- flags  output  4  {N,Z,C,V}: bit3 N, bit2 Z, bit1 C, bit0 V.

Behaviour:
- Single clock domain (clk). rst is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - busy = 0, done = 0.
  - quotient = 0, remainder = 0, flags = 4'b0000.
  - Internal registers and iteration counter = 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start = 1 and b != 0: latch a and b internally; clear the partial remainder (N+1 bits) and the counter. Next state CALC.
  - start = 1 and b == 0: next state DONE. The DONE-entry edge loads quotient = all ones, remainder = a, flags = {1,0,0,1}.
  - start = 0: remain in IDLE.
  - Outputs hold their last values.
- CALC (busy = 1): one iteration per edge.
  - Shift {rem, q} left by 1, bringing in the next dividend MSB.
  - trial = rem - {1'b0, b}, computed at N+1 bits.
  - If trial is non-negative (MSB = 0): rem = trial and q[0] = 1. Otherwise rem is kept and q[0] = 0.
  - The counter increments each iteration. On the edge completing iteration N:
    - quotient = q, remainder = rem[N-1:0].
    - flags: N = quotient[N-1], Z = (quotient == 0), C = 0, V = 0.
    - Next state DONE.
- DONE:
  - done = 1 and busy = 0 for exactly one cycle, then unconditionally IDLE.
  - start during DONE is ignored.
- Latency:
  - b != 0: done is high in the cycle following the Nth edge after the start-sampling edge (N cycles start-to-done).
  - b == 0: done is high the cycle after the start-sampling edge.
- start while busy: ignored; operands are not re-latched.
- a and b may change after start is sampled without affecting the operation in flight.
- Outputs are stable from done until the next completion. They are not cleared at the next start.
- Reset mid-operation: immediate return to IDLE, all outputs at reset values. No done pulse is produced for the aborted operation.
- All outputs are registered; no combinational path from inputs to outputs.
- Identities, for b != 0: quotient*b + remainder == a and remainder < b.

Test Plan:
- N=4: a=4'b1010 (10), b=4'b0110 (6), start 1 cycle.
  - busy=1 for 4 cycles, then done pulse.
  - quotient=4'b0001, remainder=4'b0100, flags=4'b0000.
- N=8: a=8'b11111010 (250), b=8'b00111000 (56).
  - done 8 cycles after start.
  - quotient=8'b00000100, remainder=8'b00011010, flags=4'b0000.
- N=4: a=4'b0011, b=4'b0110.
  - quotient=4'b0000, remainder=4'b0011, flags=4'b0100 (Z).
- N=4: a=4'b1111, b=4'b0001.
  - quotient=4'b1111, remainder=4'b0000, flags=4'b1000 (N).
- N=4: a=4'b0111, b=4'b0000.
  - done 1 cycle after start.
  - quotient=4'b1111, remainder=4'b0111, flags=4'b1001 (N, V).
- N=8: start 250/56.
  - Pulse start again with 9/3 at cycle 3 → ignored; result is still 4 r 26.
  - Start a new division, then assert rst at cycle 4 → busy=0, done never pulses, outputs all 0.
  - Next 9/3 → quotient 3, remainder 0.
